// File: rtl/lcd_pkg.sv
// Shared constants and state encodings for the HD44780 hex display driver.
package lcd_pkg;

    typedef enum logic [2:0] {
        StPwrup,
        StInit,
        StAddr1,
        StChar1,
        StAddr2,
        StChar2
    } lcd_state_e;

    typedef enum logic [1:0] {
        PhSetup,
        PhPulse,
        PhWait
    } lcd_phase_e;

    localparam logic [7:0] CmdFuncSet = 8'h38;
    localparam logic [7:0] CmdDispOn  = 8'h0C;
    localparam logic [7:0] CmdClear   = 8'h01;
    localparam logic [7:0] CmdEntry   = 8'h06;
    localparam logic [7:0] CmdLine1   = 8'h80;
    localparam logic [7:0] CmdLine2   = 8'hC0;

    localparam logic [2:0] LastInitIdx = 3'd3;
    localparam logic [2:0] ClearIdx    = 3'd2;
    localparam logic [2:0] LastCharIdx = 3'd7;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = CmdFuncSet;
            2'd1:    cmd = CmdDispOn;
            2'd2:    cmd = CmdClear;
            default: cmd = CmdEntry;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/nibble_ascii.sv
// Maps a 4-bit value to its uppercase ASCII hex digit.
module nibble_ascii (
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o
);

    always_comb begin
        ascii_o = 8'h00;
        if (nibble_i < 4'd10) begin
            ascii_o = 8'h30 + {4'h0, nibble_i};
        end else begin
            ascii_o = 8'h37 + {4'h0, nibble_i};
        end
    end

endmodule

// File: rtl/lcd_hex_driver.sv
// HD44780 write-only driver: power-up, init, then continuous refresh of two
// rows of 8 hex digits taken from frame-stable shadows of line1/line2.
module lcd_hex_driver
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWRUP = 750000,
    parameter int unsigned T_EN    = 25,
    parameter int unsigned T_CMD   = 2000,
    parameter int unsigned T_CLR   = 82000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] line1,
    input  logic [31:0] line2,
    output logic [7:0]  LCD_DATA,
    output logic        LCD_RS,
    output logic        LCD_EN,
    output logic        LCD_RW,
    output logic        frame_done
);

    // One counter serves power-up, pulse and post-write waits.
    localparam int unsigned MaxA   = (T_PWRUP > T_CLR) ? T_PWRUP : T_CLR;
    localparam int unsigned MaxB   = (T_CMD > T_EN) ? T_CMD : T_EN;
    localparam int unsigned CntMax = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    lcd_state_e      state_q, state_d;
    lcd_phase_e      phase_q, phase_d;
    logic [2:0]      idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     shadow1_q, shadow2_q;
    logic            en_q;

    logic [CntW-1:0] wait_last;
    logic            wait_done;
    logic [31:0]     sel_word;
    logic [3:0]      nibble;
    logic [7:0]      ascii;

    assign wait_last = (state_q == StInit && idx_q == ClearIdx) ? CntW'(T_CLR - 1)
                                                                : CntW'(T_CMD - 1);
    assign wait_done = (phase_q == PhWait) && (cnt_q == wait_last);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CntW'(1);
        if (state_q == StPwrup) begin
            if (cnt_q == CntW'(T_PWRUP - 1)) begin
                state_d = StInit;
                phase_d = PhSetup;
                idx_d   = 3'd0;
                cnt_d   = '0;
            end
        end else begin
            unique case (phase_q)
                PhSetup: begin
                    phase_d = PhPulse;
                    cnt_d   = '0;
                end
                PhPulse: begin
                    if (cnt_q == CntW'(T_EN - 1)) begin
                        phase_d = PhWait;
                        cnt_d   = '0;
                    end
                end
                PhWait: begin
                    if (wait_done) begin
                        phase_d = PhSetup;
                        cnt_d   = '0;
                        idx_d   = idx_q + 3'd1;
                        unique case (state_q)
                            StInit: begin
                                if (idx_q == LastInitIdx) begin
                                    state_d = StAddr1;
                                    idx_d   = 3'd0;
                                end
                            end
                            StAddr1: begin
                                state_d = StChar1;
                                idx_d   = 3'd0;
                            end
                            StChar1: begin
                                if (idx_q == LastCharIdx) begin
                                    state_d = StAddr2;
                                    idx_d   = 3'd0;
                                end
                            end
                            StAddr2: begin
                                state_d = StChar2;
                                idx_d   = 3'd0;
                            end
                            StChar2: begin
                                if (idx_q == LastCharIdx) begin
                                    state_d = StAddr1;
                                    idx_d   = 3'd0;
                                end
                            end
                            default: state_d = StPwrup;
                        endcase
                    end
                end
                default: phase_d = PhSetup;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StPwrup;
            phase_q   <= PhSetup;
            idx_q     <= 3'd0;
            cnt_q     <= '0;
            shadow1_q <= 32'h0;
            shadow2_q <= 32'h0;
            en_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            en_q    <= (state_d != StPwrup) && (phase_d == PhPulse);
            // Sample inputs once per frame so a row never shows a torn word.
            if (state_q == StAddr1 && phase_q == PhSetup) begin
                shadow1_q <= line1;
                shadow2_q <= line2;
            end
        end
    end

    assign sel_word = (state_q == StChar2) ? shadow2_q : shadow1_q;
    assign nibble   = sel_word[{~idx_q, 2'b00} +: 4];

    nibble_ascii u_nibble_ascii (
        .nibble_i (nibble),
        .ascii_o  (ascii)
    );

    always_comb begin
        LCD_DATA = 8'h00;
        LCD_RS   = 1'b0;
        unique case (state_q)
            StInit:  LCD_DATA = init_cmd(idx_q[1:0]);
            StAddr1: LCD_DATA = CmdLine1;
            StAddr2: LCD_DATA = CmdLine2;
            StChar1, StChar2: begin
                LCD_DATA = ascii;
                LCD_RS   = 1'b1;
            end
            default: begin
                LCD_DATA = 8'h00;
                LCD_RS   = 1'b0;
            end
        endcase
    end

    assign LCD_EN     = en_q;
    assign LCD_RW     = 1'b0;
    assign frame_done = (state_q == StChar2) && (idx_q == LastCharIdx) && wait_done;

endmodule

// File: tb/tb_lcd_hex_driver.sv
// Randomized self-checking bench: per-cycle timeline model plus literal pins.
module tb_lcd_hex_driver;

    localparam int P = 10;
    localparam int E = 2;
    localparam int C = 4;
    localparam int L = 8;
    localparam int W = 1 + E + C;
    localparam int INIT_TOT = 4 * (1 + E) + 3 * C + L;

    typedef struct {
        int         t;
        logic [7:0] d;
        logic       rs;
    } wr_t;

    logic        clock;
    logic        reset;
    logic [31:0] line1, line2;
    logic [7:0]  LCD_DATA;
    logic        LCD_RS, LCD_EN, LCD_RW, frame_done;

    int n_checks = 0;
    int n_fail = 0;
    int t;
    wr_t log_q[$];
    int  fd_t[$];
    int  widths[$];

    logic [7:0] init_seq [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    lcd_hex_driver #(
        .T_PWRUP (P),
        .T_EN    (E),
        .T_CMD   (C),
        .T_CLR   (L)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .line1      (line1),
        .line2      (line2),
        .LCD_DATA   (LCD_DATA),
        .LCD_RS     (LCD_RS),
        .LCD_EN     (LCD_EN),
        .LCD_RW     (LCD_RW),
        .frame_done (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // t = cycles since reset release (0 before the first edge after release).
    always @(posedge clock or negedge reset) begin
        if (!reset) t <= 0;
        else        t <= t + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", name, got, exp, t,
                     $time);
        end
    endtask

    function automatic logic [7:0] hex_ch(input logic [31:0] w, input int i);
        logic [3:0] n;
        n = w[31 - 4 * i -: 4];
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    function automatic int wr_len(input int k);
        return 1 + E + ((k == 2) ? L : C);
    endfunction

    // Timeline model: where in the write schedule cycle t falls, and what must be on the bus.
    logic [31:0] cap1, cap2;
    logic [7:0]  e_d, prev_d;
    logic        e_rs, e_en, e_fd, bus_chk, prev_rs, prev_en;
    int          u, v, k, base, off, pos, hi_cnt;

    always @(negedge clock) begin
        check("rw", 32'(LCD_RW), 32'd0);
        if (!reset) begin
            check("rst_en", 32'(LCD_EN), 32'd0);
            check("rst_rs", 32'(LCD_RS), 32'd0);
            check("rst_data", 32'(LCD_DATA), 32'd0);
            check("rst_fd", 32'(frame_done), 32'd0);
        end else begin
            e_en = 1'b0; e_fd = 1'b0; e_rs = 1'b0; e_d = 8'h00; bus_chk = 1'b1;
            if (t >= P) begin
                u = t - P;
                if (u < INIT_TOT) begin
                    k = 0; base = 0;
                    while (u >= base + wr_len(k)) begin
                        base += wr_len(k);
                        k++;
                    end
                    off = u - base;
                    e_d = init_seq[k];
                end else begin
                    v   = u - INIT_TOT;
                    off = v % W;
                    pos = (v / W) % 18;
                    if (pos == 0 && off == 0) begin
                        cap1 = line1;
                        cap2 = line2;
                    end
                    if (pos == 0)       e_d = 8'h80;
                    else if (pos <= 8)  begin e_d = hex_ch(cap1, pos - 1);  e_rs = 1'b1; end
                    else if (pos == 9)  e_d = 8'hC0;
                    else                begin e_d = hex_ch(cap2, pos - 10); e_rs = 1'b1; end
                    e_fd = (pos == 17 && off == W - 1);
                end
                e_en    = (off >= 1 && off <= E);
                bus_chk = (off <= E);
            end
            check("en", 32'(LCD_EN), 32'(e_en));
            check("frame_done", 32'(frame_done), 32'(e_fd));
            if (bus_chk) begin
                check("data", 32'(LCD_DATA), 32'(e_d));
                check("rs", 32'(LCD_RS), 32'(e_rs));
            end
            if (LCD_EN && prev_en) begin
                check("data_stable", 32'(LCD_DATA), 32'(prev_d));
                check("rs_stable", 32'(LCD_RS), 32'(prev_rs));
            end
            // Bus event log for the literal checks.
            if (LCD_EN && !prev_en) log_q.push_back('{t, LCD_DATA, LCD_RS});
            if (frame_done) fd_t.push_back(t);
        end
        if (LCD_EN) hi_cnt++;
        else if (hi_cnt > 0) begin
            widths.push_back(hi_cnt);
            hi_cnt = 0;
        end
        prev_en = LCD_EN;
        prev_d  = LCD_DATA;
        prev_rs = LCD_RS;
    end

    task automatic wait_writes(input int n, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clock); #1;
            ok = (log_q.size() >= n);
        end
        check("wait_writes", 32'(ok), 32'd1);
    endtask

    task automatic wait_fd(input int n, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clock); #1;
            ok = (fd_t.size() >= n);
        end
        check("wait_frame_done", 32'(ok), 32'd1);
    endtask

    task automatic chk_wr(input string name, input int i, input logic [7:0] d, input logic rs);
        if (i < log_q.size()) begin
            check(name, 32'(log_q[i].d), 32'(d));
            check({name, "_rs"}, 32'(log_q[i].rs), 32'(rs));
        end else begin
            check({name, "_missing"}, 32'(log_q.size()), 32'(i + 1));
        end
    endtask

    task automatic chk_str(input string name, input int first, input string s);
        for (int i = 0; i < 8; i++) chk_wr(name, first + i, s[i], 1'b1);
    endtask

    task automatic chk_init(input string tag);
        if (log_q.size() >= 5) begin
            check({tag, "_first_en_t"}, 32'(log_q[0].t), 32'd11);
            check({tag, "_gap0"}, 32'(log_q[1].t - log_q[0].t - (1 + E)), 32'd4);
            check({tag, "_gap1"}, 32'(log_q[2].t - log_q[1].t - (1 + E)), 32'd4);
            check({tag, "_gap_clr"}, 32'(log_q[3].t - log_q[2].t - (1 + E)), 32'd8);
            check({tag, "_gap3"}, 32'(log_q[4].t - log_q[3].t - (1 + E)), 32'd4);
        end else begin
            check({tag, "_init_writes"}, 32'(log_q.size()), 32'd5);
        end
        chk_wr({tag, "_init0"}, 0, 8'h38, 1'b0);
        chk_wr({tag, "_init1"}, 1, 8'h0C, 1'b0);
        chk_wr({tag, "_init2"}, 2, 8'h01, 1'b0);
        chk_wr({tag, "_init3"}, 3, 8'h06, 1'b0);
    endtask

    int r;

    initial begin
        hi_cnt = 0; prev_en = 1'b0; prev_d = 8'h00; prev_rs = 1'b0;
        cap1 = 32'h0; cap2 = 32'h0;
        reset = 1'b0;
        line1 = 32'h12AB_CDEF;
        line2 = 32'h0000_00F9;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;

        // Change line1 while CHAR1 character 3 is on the bus.
        wait_writes(9, 300);
        line1 = 32'hFFFF_FFFF;
        wait_fd(2, 400);

        chk_init("a");
        if (widths.size() > 0) check("en_width", 32'(widths[0]), 32'd2);
        else                   check("en_width_missing", 32'(widths.size()), 32'd1);
        chk_wr("addr1", 4, 8'h80, 1'b0);
        chk_str("row1", 5, "12ABCDEF");
        chk_wr("addr2", 13, 8'hC0, 1'b0);
        chk_str("row2", 14, "000000F9");
        chk_wr("addr1_f2", 22, 8'h80, 1'b0);
        chk_str("row1_f2", 23, "FFFFFFFF");
        if (fd_t.size() >= 2) begin
            check("fd_first", 32'(fd_t[0]), 32'd167);
            check("fd_period", 32'(fd_t[1] - fd_t[0]), 32'd126);
        end

        // Random input churn, checked cycle by cycle by the model.
        for (int i = 0; i < 400; i++) begin
            @(posedge clock); #1;
            r = int'($urandom_range(0, 7));
            if (r == 0)      line1 = $urandom;
            else if (r == 1) line2 = $urandom;
        end

        // Reset in the middle of an enable pulse.
        r = 0;
        for (int i = 0; i < 50 && r == 0; i++) begin
            @(posedge clock); #1;
            if (LCD_EN) r = 1;
        end
        check("found_pulse", 32'(r), 32'd1);
        reset = 1'b0;
        #1;
        check("async_en", 32'(LCD_EN), 32'd0);
        check("async_data", 32'(LCD_DATA), 32'd0);
        check("async_rs", 32'(LCD_RS), 32'd0);
        check("async_fd", 32'(frame_done), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        log_q.delete();
        fd_t.delete();
        widths.delete();
        line1 = $urandom;
        reset = 1'b1;

        wait_writes(5, 200);
        chk_init("b");
        wait_fd(1, 400);
        if (fd_t.size() >= 1) check("fd_after_reset", 32'(fd_t[0]), 32'd167);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
